fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side consumer for `circular_pointer_fifo`. It drains the FIFO's show-ahead head (`data_out` / `empty`) by driving `pop`, and re-presents the words on a registered valid/ready stream through a 2-entry skid buffer. It also keeps pop and delivery counters so a scoreboard can cross-check ordering and loss. It sits between the FIFO read port and any downstream sink, and supports full-rate (one word per cycle) draining.

## Interface
- `WIDTH`, 8: data word width; matches the FIFO `WIDTH`.
- `CNT_W`, 16: width of the `pop_count` and `out_count` counters.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- `enable`  in  1: when high, the block may pop the FIFO.
- `flush`  in  1: synchronous discard of buffered words.
- `fifo_empty`  in  1: FIFO `empty`.
- `fifo_data`  in  WIDTH: FIFO `data_out`; valid whenever `fifo_empty` is low.
- `fifo_pop`  out  1: FIFO `pop`; combinational.
- `out_valid`  out  1: stream valid; registered.
- `out_data`  out  WIDTH: stream data; registered.
- `out_ready`  in  1: stream ready from the sink.
- `pop_count`  out  CNT_W: number of FIFO pops since reset.
- `out_count`  out  CNT_W: number of stream transfers since reset.

## Operation
- **Storage:** 2-entry buffer `buf[0..1]`, 2-bit occupancy `occ` (0..2), 1-bit read pointer `rp`.
- **Pop rule:** `fifo_pop = rst & enable & !flush & !fifo_empty & (occ != 2)`.
  - `occ` here is the registered value; the pop decision never depends on `out_ready`.
- **Capture:** on a pop, `fifo_data` is written into slot `rp ^ occ[0]` at the same edge (write slot = `rp + occ` mod 2).
- **Stream outputs:**
  - `out_valid = (occ != 0)`.
  - `out_data = buf[rp]`; it is held stable while `out_valid & !out_ready`.
- **Accept:** `accept = out_valid & out_ready`. On accept, `rp` toggles and `out_count` increments.
- **Occupancy update:** `occ_next = occ + pop - accept`.
  - A pop and an accept in the same cycle leave `occ` unchanged.
  - At `occ == 2` a pop is impossible, so `occ` never overflows.
- **Counters:** `pop_count` increments on every `fifo_pop`. Both counters wrap modulo 2^CNT_W and are unaffected by `flush`.
- **Flush:**
  - Next edge: `occ` ← 0, `rp` ← 0.
  - No pop is issued in the flush cycle.
  - A concurrent accept in the flush cycle still counts in `out_count`.
- **Enable low:** no new pops; words already buffered are still delivered.
- **Ordering invariant:** words leave the stream in FIFO order. `pop_count - out_count - occ` is 0 except after a flush, when it equals the number of words discarded.

## Timing
- **Reset (rst low, asynchronous):**
  - `occ`, `rp` = 0; `out_valid` = 0; `out_data` = 0 (both buffer slots cleared).
  - `pop_count` and `out_count` = 0.
  - `fifo_pop` is forced to 0 while reset is asserted.
- **Reset release:** first possible pop is in the first cycle after `rst` goes high.
- **Latency:**
  - Pop at edge t puts that word on `out_data` with `out_valid` high in cycle t+1.
  - FIFO head to stream takes 1 cycle.
- **Throughput:** with `out_ready` held high and the FIFO non-empty, one pop and one accept occur per cycle in steady state (`occ` stays at 1).
- **Backpressure:** after `out_ready` drops, at most 2 further words are held. Pops stop the cycle after `occ` reaches 2.
- **Reset mid-operation:** buffered words are lost and counters clear. The FIFO is reset by the same `rst`.
- **Simultaneous `flush` and `!fifo_empty`:** no pop; the FIFO retains the word.

## Test plan
- **Reset:** hold `rst` low for 3 cycles with FIFO non-empty -> `fifo_pop` = 0, `out_valid` = 0, `out_data` = 0, both counts = 0.
- **Streaming:** push 0x11, 0x22, 0x33 into the FIFO, `out_ready` = 1, `enable` = 1 -> stream carries 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its pop; `pop_count` = `out_count` = 3; `occ` returns to 0.
- **Backpressure:** FIFO holds 0xA0..0xA4, `out_ready` = 0 -> exactly 2 pops, `occ` = 2, `out_data` stays 0xA0. Then `out_ready` = 1 -> 0xA0..0xA4 delivered in order with no gap after the first.
- **Enable gating:** `enable` = 0 with 4 words in the FIFO and `occ` = 1 -> the buffered word is delivered, no pops, FIFO `empty` stays 0, `pop_count` unchanged.
- **Flush:** `occ` = 2 (0x5A, 0x5B) and `flush` pulsed for one cycle with `out_ready` = 0 -> next cycle `out_valid` = 0, `pop_count - out_count` = 2. After that, pops resume with the next FIFO word.
- **Counter wrap:** CNT_W = 4, stream 17 words -> `pop_count` = `out_count` = 1, and data order is preserved.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// Read-port and output-stream bundle of the FIFO stream reader.
// The master view belongs to the reader; the slave view belongs to the FIFO/sink side.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_pop, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_pop, out_valid, out_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO head into a 2-entry skid buffer and re-presents it as a
// valid/ready stream, with wrapping pop and transfer counters for scoreboarding.
module fifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 flush,
    fifo_stream_reader_if.master bus,
    output logic [CNT_W-1:0]     pop_count,
    output logic [CNT_W-1:0]     out_count
);

    logic [WIDTH-1:0] buf_mem [2];
    logic [1:0]       occ;
    logic             rp;
    logic             pop;
    logic             accept;
    logic             wr_slot;

    // Pop decision ignores out_ready so draining stays full-rate under a ready sink.
    assign pop     = rst & enable & ~flush & ~bus.fifo_empty & (occ != 2'd2);
    assign accept  = bus.out_valid & bus.out_ready;
    assign wr_slot = rp ^ occ[0];

    assign bus.fifo_pop  = pop;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = buf_mem[rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            occ        <= 2'd0;
            rp         <= 1'b0;
            pop_count  <= '0;
            out_count  <= '0;
        end else begin
            if (pop) begin
                buf_mem[wr_slot] <= bus.fifo_data;
                pop_count        <= pop_count + 1'b1;
            end
            if (accept) begin
                out_count <= out_count + 1'b1;
            end
            // Flush discards buffered words but leaves both counters running.
            if (flush) begin
                occ <= 2'd0;
                rp  <= 1'b0;
            end else begin
                occ <= occ + {1'b0, pop} - {1'b0, accept};
                if (accept) begin
                    rp <= ~rp;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue-based model
// of the FIFO contents and the words held between pop and stream transfer.
module tb_fifo_stream_reader;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CNT_MASK = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] pop_count;
    logic [CNT_W-1:0] out_count;

    fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .flush     (flush),
        .bus       (bus),
        .pop_count (pop_count),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] mbuf [$];
    int mpop;
    int mout;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic cycle(input logic en, input logic fl, input logic rdy);
        bit exp_pop;
        bit exp_acc;
        enable         = en;
        flush          = fl;
        bus.out_ready  = rdy;
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        @(negedge clk);
        exp_pop = en && !fl && (fifo_q.size() != 0) && (mbuf.size() < 2);
        exp_acc = (mbuf.size() != 0) && rdy;
        check("fifo_pop", bus.fifo_pop, exp_pop);
        check("out_valid", bus.out_valid, mbuf.size() != 0);
        if (mbuf.size() != 0) check("out_data", bus.out_data, mbuf[0]);
        check("pop_count", pop_count, mpop & CNT_MASK);
        check("out_count", out_count, mout & CNT_MASK);
        if (exp_acc) begin
            void'(mbuf.pop_front());
            mout++;
        end
        if (exp_pop) begin
            mbuf.push_back(fifo_q.pop_front());
            mpop++;
        end
        if (fl) mbuf.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        enable         = 1'b1;
        flush          = 1'b0;
        bus.out_ready  = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.fifo_data  = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("rst_pop", bus.fifo_pop, 0);
            check("rst_valid", bus.out_valid, 0);
            check("rst_data", bus.out_data, 0);
            check("rst_pop_count", pop_count, 0);
            check("rst_out_count", out_count, 0);
        end
        fifo_q.delete();
        mbuf.delete();
        mpop = 0;
        mout = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.out_ready  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        apply_reset();

        // streaming
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        check("stream_pops", pop_count, 3);
        check("stream_outs", out_count, 3);
        check("stream_drained", bus.out_valid, 0);

        // backpressure
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'hA0 + 8'(i));
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        check("bp_pops", 4'(pop_count - 4'd3), 2);
        check("bp_hold_data", bus.out_data, 8'hA0);
        repeat (7) cycle(1'b1, 1'b0, 1'b1);
        check("bp_outs", out_count, 8);

        // enable gating with one word buffered
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'hC0 + 8'(i));
        cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        check("en_pop_count", pop_count, 9);
        check("en_not_empty", bus.fifo_empty, 0);
        repeat (8) cycle(1'b1, 1'b0, 1'b1);

        // flush with two words buffered
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h5B);
        fifo_q.push_back(8'h5C);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check("flush_valid", bus.out_valid, 0);
        check("flush_diff", 4'(pop_count - out_count), 2);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);

        // counter wrap
        apply_reset();
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h40 + i));
        repeat (20) cycle(1'b1, 1'b0, 1'b1);
        check("wrap_pop", pop_count, 1);
        check("wrap_out", out_count, 1);

        // random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                #2;
                rst = 1'b0;
                #1;
                check("async_pop", bus.fifo_pop, 0);
                check("async_valid", bus.out_valid, 0);
                check("async_data", bus.out_data, 0);
                check("async_pop_count", pop_count, 0);
                check("async_out_count", out_count, 0);
                apply_reset();
            end
            if ($urandom_range(0, 1) == 0 && fifo_q.size() < 8)
                fifo_q.push_back(WIDTH'($urandom));
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                  (i < 150) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
